// File: rtl/chip8_sprite_draw.sv
// Chip8 DXYN sprite draw engine: fetches sprite rows from main memory and XORs them into a 1-bit framebuffer.
// Define CHIP8_SPRITE_WRAP_EN to wrap off-edge pixels instead of clipping them.
module chip8_sprite_draw #(
    parameter int MEM_AW = 12,
    parameter int FB_XW  = 6,
    parameter int FB_YW  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             vx,
    input  logic [7:0]             vy,
    input  logic [3:0]             n,
    input  logic [MEM_AW-1:0]      i_addr,
    output logic [MEM_AW-1:0]      mem_addr,
    input  logic [7:0]             mem_rdata,
    output logic [FB_YW+FB_XW-1:0] fb_addr,
    input  logic                   fb_rdata,
    output logic                   fb_we,
    output logic                   fb_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   collision
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_SCAN, S_PIX_WR, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [FB_XW-1:0]         x0_q, x0_d;
    logic [FB_YW-1:0]         y0_q, y0_d;
    logic [3:0]               n_q, n_d;
    logic [MEM_AW-1:0]        base_q, base_d;
    logic [3:0]               row_q, row_d;
    logic [2:0]               col_q, col_d;
    logic [7:0]               sprite_q, sprite_d;
    logic [MEM_AW-1:0]        mem_addr_q, mem_addr_d;
    logic [FB_YW+FB_XW-1:0]   fb_addr_q, fb_addr_d;
    logic                     fb_we_q, fb_we_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     collision_q, collision_d;

    logic [FB_XW:0]           px_full;
    logic [FB_YW:0]           py_full;
    logic                     clipped;
    logic                     step;
    logic [3:0]               row_nx;
    logic [2:0]               col_nx;
    logic                     unused_bits;

    assign px_full = {1'b0, x0_q} + (FB_XW+1)'(col_q);
    assign py_full = {1'b0, y0_q} + (FB_YW+1)'(row_q);
`ifdef CHIP8_SPRITE_WRAP_EN
    assign clipped = 1'b0;
    assign unused_bits = ^{vx[7:FB_XW], vy[7:FB_YW], px_full[FB_XW], py_full[FB_YW]};
`else
    assign clipped = px_full[FB_XW] | py_full[FB_YW];
    assign unused_bits = ^{vx[7:FB_XW], vy[7:FB_YW]};
`endif
    assign row_nx = row_q + 4'd1;
    assign col_nx = col_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        n_d         = n_q;
        base_d      = base_q;
        row_d       = row_q;
        col_d       = col_q;
        sprite_d    = sprite_q;
        mem_addr_d  = mem_addr_q;
        fb_addr_d   = fb_addr_q;
        collision_d = collision_q;
        fb_we_d     = 1'b0;
        done_d      = 1'b0;
        step        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d        = vx[FB_XW-1:0];
                    y0_d        = vy[FB_YW-1:0];
                    n_d         = n;
                    base_d      = i_addr;
                    collision_d = 1'b0;
                    row_d       = '0;
                    col_d       = '0;
                    if (n == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = i_addr;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                sprite_d  = mem_rdata;
                col_d     = '0;
                fb_addr_d = {y0_q + FB_YW'(row_q), x0_q};
                state_d   = S_SCAN;
            end
            // fb_addr already holds this column's pixel, so fb_rdata is valid in PIX_WR
            S_SCAN: begin
                if (sprite_q[~col_q] && !clipped) begin
                    fb_we_d = 1'b1;
                    state_d = S_PIX_WR;
                end else begin
                    step = 1'b1;
                end
            end
            S_PIX_WR: begin
                collision_d = collision_q | fb_rdata;
                step        = 1'b1;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (step) begin
            if (col_q == 3'd7) begin
                row_d = row_nx;
                if (row_nx == n_q) begin
                    state_d = S_DONE;
                end else begin
                    mem_addr_d = base_q + MEM_AW'(row_nx);
                    state_d    = S_FETCH;
                end
            end else begin
                col_d     = col_nx;
                fb_addr_d = {y0_q + FB_YW'(row_q), x0_q + FB_XW'(col_nx)};
                state_d   = S_SCAN;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            n_q         <= '0;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sprite_q    <= '0;
            mem_addr_q  <= '0;
            fb_addr_q   <= '0;
            fb_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            n_q         <= n_d;
            base_q      <= base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sprite_q    <= sprite_d;
            mem_addr_q  <= mem_addr_d;
            fb_addr_q   <= fb_addr_d;
            fb_we_q     <= fb_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            collision_q <= collision_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign fb_addr   = fb_addr_q;
    assign fb_we     = fb_we_q;
    assign fb_wdata  = fb_we_q & ~fb_rdata;
    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;
endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Scoreboard bench for chip8_sprite_draw: directed draws against synchronous memory and framebuffer models.
module tb_chip8_sprite_draw;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  vx = '0, vy = '0;
    logic [3:0]  n = '0;
    logic [11:0] i_addr = '0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic [10:0] fb_addr;
    logic        fb_rdata = 1'b0;
    logic        fb_we, fb_wdata, busy, done, collision;

    chip8_sprite_draw #(.MEM_AW(12), .FB_XW(6), .FB_YW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n),
        .i_addr(i_addr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_we(fb_we), .fb_wdata(fb_wdata),
        .busy(busy), .done(done), .collision(collision)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];
    logic       fb  [0:2047];

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        fb_rdata  <= fb[fb_addr];
        if (fb_we) fb[fb_addr] <= fb_wdata;
    end

    typedef struct { int addr; int d; } wr_t;
    typedef struct { int lat; int coll; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int cyc = 0;
    int start_cyc = 0;
    int passed = 0;
    int total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (fb_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", int'(fb_addr), -1);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", int'(fb_addr), w.addr);
                    chk("wr_data", int'(fb_wdata), w.d);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
                    chk("collision", int'(collision), e.coll);
                    chk("writes_pending", wq.size(), 0);
                end
            end
        end
    end

    task automatic exp_wr(input int y, input int x, input int d);
        wr_t w;
        w.addr = y * 64 + x;
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic exp_done(input int lat, input int coll);
        dn_t e;
        e.lat = lat;
        e.coll = coll;
        dq.push_back(e);
    endtask

    task automatic draw(input int x, input int y, input int nn, input int ia);
        @(negedge clk);
        vx = 8'(x); vy = 8'(y); n = 4'(nn); i_addr = 12'(ia);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            if (dq.size() == 0) break;
        end
        if (k == 300) begin
            chk("timeout", 1, 0);
            dq.delete();
            wq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        for (int a = 0; a < 2048; a++) fb[a] = 1'b0;
        mem[12'h200] = 8'h80;
        mem[12'h201] = 8'hFF;
        mem[12'h202] = 8'hC0;
        mem[12'h203] = 8'h80;
        mem[12'h204] = 8'h80;
        mem[12'h205] = 8'hFF;
        mem[12'hFFF] = 8'hA0;
        mem[12'h000] = 8'h41;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_collision", int'(collision), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_wdata", int'(fb_wdata), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        reset = 1'b0;

        // single pixel on blank framebuffer, then the same draw erases it
        exp_wr(0, 0, 1); exp_done(12, 0);
        draw(0, 0, 1, 12'h200); wait_done();
        exp_wr(0, 0, 0); exp_done(12, 1);
        draw(0, 0, 1, 12'h200); wait_done();

        // right-edge sprite
        exp_wr(0, 60, 1); exp_wr(0, 61, 1); exp_wr(0, 62, 1); exp_wr(0, 63, 1);
`ifdef CHIP8_SPRITE_WRAP_EN
        exp_wr(0, 0, 1); exp_wr(0, 1, 1); exp_wr(0, 2, 1); exp_wr(0, 3, 1);
`endif
        exp_done(-1, 0);
        draw(60, 0, 1, 12'h201); wait_done();

        // wrapped origin (2,3) and I+row wrapping 0xFFF -> 0x000
        exp_wr(3, 2, 1); exp_wr(3, 4, 1); exp_wr(4, 3, 1); exp_wr(4, 9, 1);
        exp_done(25, 0);
        draw(66, 35, 2, 12'hFFF); wait_done();

        // n=0 completes in one cycle with no framebuffer writes
        exp_done(1, 0);
        draw(1, 1, 0, 12'h200); wait_done();

        // start while busy is ignored
        exp_wr(1, 10, 1); exp_wr(1, 11, 1); exp_done(13, 0);
        draw(10, 1, 1, 12'h202);
        repeat (3) @(negedge clk);
        start = 1'b1; vx = 8'd20; vy = 8'd20; n = 4'd3; i_addr = 12'h205;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // bottom-edge sprite: second row lands off-screen
        exp_wr(31, 5, 1);
`ifdef CHIP8_SPRITE_WRAP_EN
        exp_wr(0, 5, 1);
`endif
        exp_done(-1, 0);
        draw(5, 31, 2, 12'h203); wait_done();

        // reset during the first pixel write aborts the draw
        exp_wr(10, 0, 1);
        draw(0, 10, 1, 12'h205);
        begin
            int k;
            for (k = 0; k < 30; k++) begin
                if (fb_we) break;
                @(negedge clk);
            end
            if (k == 30) chk("pix_wr_timeout", 1, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_fb_we", int'(fb_we), 0);
        chk("abort_collision", int'(collision), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        wq.delete();
        repeat (2) @(negedge clk);

        // redraw: the pixel written on the reset edge now collides
        exp_wr(10, 0, 0);
        for (int x = 1; x < 8; x++) exp_wr(10, x, 1);
        exp_done(19, 1);
        draw(0, 10, 1, 12'h205); wait_done();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
